shared_op_arbiter: RTL and testbench

Parametrised, sequential successor to our two-output shared-logic block. One shared WIDTH-bit adder serves CHANNELS requesters instead of a fixed select-driven pair. A round-robin arbiter grants access. Each result sits in a one-entry output buffer, tagged with its channel, under a valid/ready handshake. The block sits between per-channel operand producers and a single downstream result consumer.

---
 rtl/shared_op_arbiter.sv | 95 +++++++++
 tb/tb_shared_op_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/shared_op_arbiter.sv
// Round-robin arbitrated shared adder with a one-entry, channel-tagged result buffer.
// Define SHARED_OP_SUB_EN to add the per-channel op_sub input and the subtract path.
module shared_op_arbiter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          req_valid,
  output logic [CHANNELS-1:0]          req_ready,
  input  logic [CHANNELS*WIDTH-1:0]    op_a,
  input  logic [CHANNELS*WIDTH-1:0]    op_b,
`ifdef SHARED_OP_SUB_EN
  input  logic [CHANNELS-1:0]          op_sub,
`endif
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [WIDTH:0]               res_data,
  output logic [$clog2(CHANNELS)-1:0]  res_chan,
  output logic [15:0]                  accept_cnt
);

  localparam int CW = $clog2(CHANNELS);

  // Handshakes: a transfer happens on any clk edge where valid and ready are both 1.
  // req_ready is combinational from req_valid, the pointer, res_valid and res_ready.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state;
  logic [CW-1:0]  ptr;
  logic [CW-1:0]  winner;
  logic [CW-1:0]  ptr_next;
  logic [CW:0]    idx_ext;
  logic           found;
  logic           slot_free;
  logic           grant;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH:0]   result;

  assign res_valid = (state == FULL);
  assign slot_free = (state == EMPTY) || res_ready;

  // Ascending search from the pointer, wrapping to channel 0.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    idx_ext = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx_ext = {1'b0, ptr} + (CW+1)'(k);
      if (idx_ext >= (CW+1)'(CHANNELS)) idx_ext = idx_ext - (CW+1)'(CHANNELS);
      if (!found && req_valid[idx_ext[CW-1:0]]) begin
        found  = 1'b1;
        winner = idx_ext[CW-1:0];
      end
    end
  end

  assign grant = found && slot_free && !rst;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  assign ptr_next = (winner == CW'(CHANNELS-1)) ? '0 : winner + 1'b1;
  assign sel_a    = op_a[winner*WIDTH +: WIDTH];
  assign sel_b    = op_b[winner*WIDTH +: WIDTH];

`ifdef SHARED_OP_SUB_EN
  assign result = op_sub[winner] ? ({1'b0, sel_a} - {1'b0, sel_b})
                                 : ({1'b0, sel_a} + {1'b0, sel_b});
`else
  assign result = {1'b0, sel_a} + {1'b0, sel_b};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      res_data   <= '0;
      res_chan   <= '0;
      accept_cnt <= '0;
      ptr        <= '0;
    end else if (grant) begin
      state      <= FULL;
      res_data   <= result;
      res_chan   <= winner;
      accept_cnt <= accept_cnt + 16'd1;
      ptr        <= ptr_next;
    end else if (state == FULL && res_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_shared_op_arbiter.sv
// Directed self-checking bench for shared_op_arbiter (WIDTH=8, CHANNELS=4).
module tb_shared_op_arbiter;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;

  logic                      clk;
  logic                      rst;
  logic [CHANNELS-1:0]       req_valid;
  logic [CHANNELS-1:0]       req_ready;
  logic [CHANNELS*WIDTH-1:0] op_a;
  logic [CHANNELS*WIDTH-1:0] op_b;
`ifdef SHARED_OP_SUB_EN
  logic [CHANNELS-1:0]       op_sub;
`endif
  logic                      res_valid;
  logic                      res_ready;
  logic [WIDTH:0]            res_data;
  logic [1:0]                res_chan;
  logic [15:0]               accept_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH:0] exp_q[$];
  logic [1:0]     chan_q[$];

  shared_op_arbiter #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op_a       (op_a),
    .op_b       (op_b),
`ifdef SHARED_OP_SUB_EN
    .op_sub     (op_sub),
`endif
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_chan   (res_chan),
    .accept_cnt (accept_cnt)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] a, input logic [7:0] b);
    op_a[ch*WIDTH +: WIDTH] = a;
    op_b[ch*WIDTH +: WIDTH] = b;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    res_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
`ifdef SHARED_OP_SUB_EN
    op_sub    = '0;
`endif

    // Reset held two cycles with every channel requesting
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_data", 32'(res_data), 32'h0);
    check("rst_res_chan", 32'(res_chan), 32'h0);
    check("rst_accept_cnt", 32'(accept_cnt), 32'h0);
    rst = 1'b0;
    req_valid = 4'b0000;
    tick();

    // Single request from channel 2
    set_ch(2, 8'h12, 8'h34);
    req_valid = 4'b0100;
    res_ready = 1'b1;
    settle();
    check("single_req_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    check("single_res_valid", 32'(res_valid), 32'h1);
    check("single_res_data", 32'(res_data), 32'h046);
    check("single_res_chan", 32'(res_chan), 32'h2);
    check("single_accept_cnt", 32'(accept_cnt), 32'h1);
    tick();
    check("single_drained", 32'(res_valid), 32'h0);

    // Round robin from a fresh pointer, all channels requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < CHANNELS; i++) set_ch(i, 8'hF0 + 8'(i), 8'h20 + 8'(i));
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      settle();
      check("rr_req_ready", 32'(req_ready), 32'(1) << (n % 4));
      chan_q.push_back(2'(n % 4));
      exp_q.push_back(9'(8'hF0 + 8'(n % 4)) + 9'(8'h20 + 8'(n % 4)));
      tick();
      check("rr_res_chan", 32'(res_chan), 32'(chan_q.pop_front()));
      check("rr_res_data", 32'(res_data), 32'(exp_q.pop_front()));
    end
    check("rr_accept_cnt", 32'(accept_cnt), 32'd8);
    req_valid = 4'b0000;
    tick();
    check("rr_drained", 32'(res_valid), 32'h0);

    // Backpressure: ch1 overflow result held while ch3 waits
    set_ch(1, 8'hFF, 8'hFF);
    set_ch(3, 8'h01, 8'h02);
    req_valid = 4'b0010;
    res_ready = 1'b0;
    settle();
    check("bp_ch1_ready", 32'(req_ready), 32'h2);
    tick();
    check("bp_ovf_data", 32'(res_data), 32'h1FE);
    check("bp_ovf_chan", 32'(res_chan), 32'h1);
    req_valid = 4'b1000;
    for (int n = 0; n < 3; n++) begin
      settle();
      check("bp_stall_ready", 32'(req_ready), 32'h0);
      tick();
      check("bp_hold_valid", 32'(res_valid), 32'h1);
      check("bp_hold_data", 32'(res_data), 32'h1FE);
      check("bp_hold_chan", 32'(res_chan), 32'h1);
    end
    res_ready = 1'b1;
    settle();
    check("bp_refill_ready", 32'(req_ready), 32'h8);
    tick();
    check("bp_refill_valid", 32'(res_valid), 32'h1);
    check("bp_refill_chan", 32'(res_chan), 32'h3);
    check("bp_refill_data", 32'(res_data), 32'h003);
    check("bp_accept_cnt", 32'(accept_cnt), 32'd10);

    // Reset while the buffer is full
    rst = 1'b1;
    res_ready = 1'b0;
    req_valid = 4'b1010;
    settle();
    check("mid_rst_req_ready", 32'(req_ready), 32'h0);
    tick();
    check("mid_rst_valid", 32'(res_valid), 32'h0);
    check("mid_rst_data", 32'(res_data), 32'h0);
    check("mid_rst_cnt", 32'(accept_cnt), 32'h0);
    rst = 1'b0;
    res_ready = 1'b1;
    settle();
    check("post_rst_first", 32'(req_ready), 32'h2);
    tick();
    check("post_rst_chan1", 32'(res_chan), 32'h1);
    settle();
    check("post_rst_second", 32'(req_ready), 32'h8);
    tick();
    check("post_rst_chan3", 32'(res_chan), 32'h3);
    req_valid = 4'b0000;
    res_ready = 1'b0;
    tick();
    check("idle_hold_valid", 32'(res_valid), 32'h1);
    check("idle_hold_chan", 32'(res_chan), 32'h3);
    check("idle_hold_cnt", 32'(accept_cnt), 32'd2);

`ifdef SHARED_OP_SUB_EN
    // Subtraction path with borrow
    rst = 1'b1;
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    set_ch(0, 8'h05, 8'h07);
    op_sub = 4'b0001;
    req_valid = 4'b0001;
    tick();
    check("sub_borrow", 32'(res_data), 32'h1FE);
    set_ch(0, 8'h07, 8'h05);
    tick();
    check("sub_plain", 32'(res_data), 32'h002);
    op_sub = 4'b0000;
    tick();
    check("sub_off_add", 32'(res_data), 32'h00C);
    req_valid = 4'b0000;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
